mtw_top: RTL



---
 rtl/mtw_top.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mtw_top.sv
// mtw_top: Mersenne Twister random word generator (MT19937 / MT19937-64).
//
// After an init pulse the state array is filled from the seed at one word per
// cycle, then words are twisted on the fly and tempered. Each tempered word
// goes into a small output buffer that feeds a registered ready/valid output.
// The generator advances only while the buffer has room, so the consumer can
// stall it at any time without losing or repeating a word.
//
// Parameters:
//   W     word width, 32 (MT19937) or 64 (MT19937-64)
//   OBUF  output buffer depth in words, at least 2
//
// Ports:
//   clk      clock
//   reset    asynchronous active-high reset
//   init     one-cycle pulse: load seed and (re)start state initialisation
//   seed     seed value, sampled when init=1
//   dout     tempered output word (registered)
//   dout_en  dout valid (registered)
//   update   consumer accept; a word is consumed when dout_en && update
//   busy     state initialisation in progress
//
// Build option:
//   MTW_DEFAULT_SEED_EN  when defined, leaving reset starts initialisation
//                        with seed 5489 without an init pulse.
module mtw_top #(
    parameter int W    = 32,
    parameter int OBUF = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic [W-1:0] seed,
    output logic [W-1:0] dout,
    output logic         dout_en,
    input  logic         update,
    output logic         busy
);

    if (!(W == 32 || W == 64)) begin : g_bad_w
        $error("mtw_top: W must be 32 or 64");
    end
    if (OBUF < 2) begin : g_bad_obuf
        $error("mtw_top: OBUF must be at least 2");
    end

    localparam int N = (W == 64) ? 312 : 624;
    localparam int M = (W == 64) ? 156 : 397;
    localparam int U = (W == 64) ? 29 : 11;
    localparam int S = (W == 64) ? 17 : 7;
    localparam int T = (W == 64) ? 37 : 15;
    localparam int L = (W == 64) ? 43 : 18;
    localparam int R = 31;

    localparam logic [W-1:0] A = W'((W == 64) ? 64'hB502_6F5A_A966_19E9 : 64'h9908_B0DF);
    localparam logic [W-1:0] D = W'((W == 64) ? 64'h5555_5555_5555_5555 : 64'hFFFF_FFFF);
    localparam logic [W-1:0] B = W'((W == 64) ? 64'h71D6_7FFF_EDA6_0000 : 64'h9D2C_5680);
    localparam logic [W-1:0] C = W'((W == 64) ? 64'hFFF7_EEE0_0000_0000 : 64'hEFC6_0000);
    localparam logic [W-1:0] F = W'((W == 64) ? 64'd6364136223846793005 : 64'd1812433253);
    localparam logic [W-1:0] LOWER    = W'((64'd1 << R) - 64'd1);
    localparam logic [W-1:0] UPPER    = ~LOWER;
    localparam logic [W-1:0] DEF_SEED = W'(64'd5489);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(OBUF);
    localparam int CW = $clog2(OBUF + 1);

    typedef enum logic [1:0] {IDLE, INIT, PRIME, RUN} state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_p1;
    logic [IW-1:0]   idx_m;
    logic [IW:0]     idx_m_sum;
    logic [W-1:0]    seed_q;
    logic [W-1:0]    prev_q;
    logic [W-1:0]    init_val;
    logic [W-1:0]    twisted;
    logic [W-1:0]    tempered;
    logic [W-1:0]    mt [N];
    logic [W-1:0]    obuf_mem [OBUF];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            pop;
    logic            gen;
    logic            init_we;
    logic            auto_start;

    function automatic logic [W-1:0] temper(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = x ^ ((x >> U) & D);
        y = y ^ ((y << S) & B);
        y = y ^ ((y << T) & C);
        y = y ^ (y >> L);
        return y;
    endfunction

    function automatic logic [W-1:0] twist(input logic [W-1:0] cur,
                                           input logic [W-1:0] nxt,
                                           input logic [W-1:0] far);
        logic [W-1:0] y;
        y = (cur & UPPER) | (nxt & LOWER);
        return far ^ (y >> 1) ^ (y[0] ? A : '0);
    endfunction

    function automatic logic [W-1:0] init_step(input logic [W-1:0] p,
                                               input logic [IW-1:0] i);
        return F * (p ^ (p >> (W - 2))) + W'(i);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef MTW_DEFAULT_SEED_EN
    // Set while in reset so the first clock after release starts INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) auto_start <= 1'b1;
        else       auto_start <= 1'b0;
    end
`else
    assign auto_start = 1'b0;
`endif

    // Index arithmetic for the on-the-fly twist. The state array is read
    // combinationally and written at the same edge that consumes the read,
    // so indices already rewritten in this pass (i+M wrapping below i, and
    // mt[0] when i=N-1) naturally return their new values.
    assign idx_p1    = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    assign idx_m_sum = {1'b0, idx} + (IW + 1)'(M);
    assign idx_m     = (idx_m_sum >= (IW + 1)'(N)) ? IW'(idx_m_sum - (IW + 1)'(N))
                                                   : IW'(idx_m_sum);

    assign init_val = (idx == '0) ? seed_q : init_step(prev_q, idx);
    assign twisted  = twist(mt[idx], mt[idx_p1], mt[idx_m]);
    assign tempered = temper(twisted);

    // A buffered word moves to the output register when the register is
    // empty or being consumed this cycle.
    assign pop = (count != '0) && (!dout_en || update);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        gen        = 1'b0;
        init_we    = 1'b0;
        case (state)
            IDLE: begin
                if (init || auto_start) state_next = INIT;
            end
            INIT: begin
                busy    = 1'b1;
                init_we = !init;
                if (init)                    state_next = INIT;
                else if (idx == IW'(N - 1))  state_next = PRIME;
            end
            PRIME, RUN: begin
                // Room exists if the buffer is not full or a word leaves now.
                gen = !init && ((count < CW'(OBUF)) || pop);
                if (init)                           state_next = INIT;
                else if (state == PRIME && gen)     state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dout    <= '0;
            dout_en <= 1'b0;
        end else begin
            if (init || (state == IDLE && auto_start)) idx <= '0;
            else if (init_we || gen)                   idx <= idx_p1;

            // A restart flushes the buffer; a word accepted in the same
            // cycle is simply dropped as consumed.
            if (init) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (gen) wptr <= ptr_inc(wptr);
                if (pop) rptr <= ptr_inc(rptr);
                count <= count + CW'(gen) - CW'(pop);
            end

            if (init) begin
                dout_en <= 1'b0;
            end else if (pop) begin
                dout    <= obuf_mem[rptr];
                dout_en <= 1'b1;
            end else if (update) begin
                dout_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init || (state == IDLE && auto_start)) seed_q <= init ? seed : DEF_SEED;
        if (init_we) prev_q <= init_val;
        if (init_we)  mt[idx] <= init_val;
        else if (gen) mt[idx] <= twisted;
        if (gen) obuf_mem[wptr] <= tempered;
    end

endmodule
